// File: rtl/imm_pkg.sv
// Shared immediate-format encodings and occupancy state for the RISC-V immediate generator.
package imm_pkg;

    localparam int unsigned IMMSRC_W = 3;

    localparam logic [IMMSRC_W-1:0] IMM_I   = 3'b000;
    localparam logic [IMMSRC_W-1:0] IMM_S   = 3'b001;
    localparam logic [IMMSRC_W-1:0] IMM_B   = 3'b010;
    localparam logic [IMMSRC_W-1:0] IMM_J   = 3'b011;
    localparam logic [IMMSRC_W-1:0] IMM_U   = 3'b100;
    localparam logic [IMMSRC_W-1:0] IMM_Z   = 3'b101;
    localparam logic [IMMSRC_W-1:0] IMM_SH  = 3'b110;
    localparam logic [IMMSRC_W-1:0] IMM_RSV = 3'b111;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/imm_format.sv
// Combinational immediate formatter: instruction word + format select -> XLEN immediate.
module imm_format
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]          instr,
    input  logic [IMMSRC_W-1:0]  immsrc,
    output logic [XLEN-1:0]      immext_c,
    output logic                 illegal_c
);

    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_j;
    logic signed [31:0] imm_u;
    logic [5:0]         shamt;
    logic               unused_bits;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    // RV64 shifts take a 6-bit shamt; RV32 ignores instr[25].
    generate
        if (XLEN == 64) begin : g_shamt64
            assign shamt = instr[25:20];
        end else begin : g_shamt32
            assign shamt = {1'b0, instr[24:20]};
        end
    endgenerate

    assign unused_bits = ^{instr[6:0], instr[25]};

    always_comb begin
        immext_c  = '0;
        illegal_c = 1'b0;
        case (immsrc)
            IMM_I:   immext_c = XLEN'(imm_i);
            IMM_S:   immext_c = XLEN'(imm_s);
            IMM_B:   immext_c = XLEN'(imm_b);
            IMM_J:   immext_c = XLEN'(imm_j);
            IMM_U:   immext_c = XLEN'(imm_u);
            IMM_Z:   immext_c = XLEN'(instr[19:15]);
            IMM_SH:  immext_c = XLEN'(shamt);
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate generator with 2-entry skid buffer and sideband tag.
// Optional simulation trace of every accepted input: define IMM_EXTEND_PIPE_TRACE_EN.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [IMMSRC_W-1:0]  in_immsrc,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_immext,
    output logic [IMMSRC_W-1:0]  out_immsrc,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_illegal
);

    occ_state_e state, state_d;

    logic [XLEN-1:0]     fmt_imm;
    logic                fmt_ill;
    logic [XLEN-1:0]     skid_imm;
    logic [IMMSRC_W-1:0] skid_src;
    logic [TAG_W-1:0]    skid_tag;
    logic                skid_ill;

    logic in_xfer_c;
    logic out_xfer_c;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    // Format on the input side so both registers hold finished immediates.
    imm_format #(.XLEN(XLEN)) u_fmt (
        .instr     (in_instr),
        .immsrc    (in_immsrc),
        .immext_c  (fmt_imm),
        .illegal_c (fmt_ill)
    );

    assign in_xfer_c  = in_valid && in_ready;
    assign out_xfer_c = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            in_ready  <= (state_d != FULL);
            out_valid <= (state_d != EMPTY);
        end
    end

    always_comb begin
        state_d        = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_xfer_c) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer_c && out_xfer_c) begin
                    load_main_in = 1'b1;
                end else if (in_xfer_c) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (out_xfer_c) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer_c) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Main output register and skid register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_immext  <= '0;
            out_immsrc  <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
            skid_imm    <= '0;
            skid_src    <= '0;
            skid_tag    <= '0;
            skid_ill    <= 1'b0;
        end else begin
            if (load_main_in) begin
                out_immext  <= fmt_imm;
                out_immsrc  <= in_immsrc;
                out_tag     <= in_tag;
                out_illegal <= fmt_ill;
            end else if (load_main_skid) begin
                out_immext  <= skid_imm;
                out_immsrc  <= skid_src;
                out_tag     <= skid_tag;
                out_illegal <= skid_ill;
            end
            if (load_skid) begin
                skid_imm <= fmt_imm;
                skid_src <= in_immsrc;
                skid_tag <= in_tag;
                skid_ill <= fmt_ill;
            end
        end
    end

`ifdef IMM_EXTEND_PIPE_TRACE_EN
    function automatic string fmt_name(input logic [IMMSRC_W-1:0] s);
        case (s)
            IMM_I:   return "I";
            IMM_S:   return "S";
            IMM_B:   return "B";
            IMM_J:   return "J";
            IMM_U:   return "U";
            IMM_Z:   return "Z";
            IMM_SH:  return "SH";
            default: return "ILL";
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset && in_xfer_c) begin
            $display("[imm_extend_pipe] %s instr=%h imm=%h tag=%h",
                     fmt_name(in_immsrc), in_instr, fmt_imm, in_tag);
        end
    end
`else
    // Trace disabled: no simulation-only logic.
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances driven by shared inputs, checked against a spec-level model.
module tb_imm_extend_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_immsrc;
    logic [3:0]  in_tag;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32;
    logic [2:0]  src32;
    logic [3:0]  tag32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64;
    logic [2:0]  src64;
    logic [3:0]  tag64;

    int passed;
    int total;

    typedef struct {
        logic [63:0] i64;
        logic [31:0] i32;
        logic [2:0]  src;
        logic [3:0]  tag;
        logic        ill;
    } exp_t;

    exp_t q[$];

    imm_extend_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_immext(imm32), .out_immsrc(src32), .out_tag(tag32), .out_illegal(ill32)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_immext(imm64), .out_immsrc(src64), .out_tag(tag64), .out_illegal(ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference immediate built from field values with plain arithmetic.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, input int xlen);
        longint v;
        case (src)
            3'd0: begin v = 64'(ins[31:20]); if (ins[31]) v -= 64'd4096; end
            3'd1: begin v = 64'({ins[31:25], ins[11:7]}); if (ins[31]) v -= 64'd4096; end
            3'd2: begin
                v = (64'(ins[31]) << 12) + (64'(ins[7]) << 11) + (64'(ins[30:25]) << 5) + (64'(ins[11:8]) << 1);
                if (ins[31]) v -= 64'd8192;
            end
            3'd3: begin
                v = (64'(ins[31]) << 20) + (64'(ins[19:12]) << 12) + (64'(ins[20]) << 11) + (64'(ins[30:21]) << 1);
                if (ins[31]) v -= 64'd2097152;
            end
            3'd4: begin v = 64'(ins[31:12]) << 12; if (ins[31]) v -= 64'h1_0000_0000; end
            3'd5: v = 64'(ins[19:15]);
            3'd6: v = (xlen == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
            default: v = 64'd0;
        endcase
        if (xlen == 32) return {32'h0, v[31:0]};
        return v;
    endfunction

    task automatic offer(input logic [31:0] i, input logic [2:0] s, input logic [3:0] t);
        in_valid  = 1'b1;
        in_instr  = i;
        in_immsrc = s;
        in_tag    = t;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_immsrc = '0; in_tag = '0;
        @(negedge clk);
        total++;
        if ({out_valid32, in_ready32, imm32, src32, tag32, ill32} !== '0)
            $display("FAIL reset32: got %h expected 0", {out_valid32, in_ready32, imm32, src32, tag32, ill32});
        else passed++;
        total++;
        if ({out_valid64, in_ready64, imm64, src64, tag64, ill64} !== '0)
            $display("FAIL reset64: got %h expected 0", {out_valid64, in_ready64, imm64, src64, tag64, ill64});
        else passed++;
        reset = 1'b0;
        #1;
        total++;
        if (in_ready32 !== 1'b0) $display("FAIL ready_before_edge: got %b expected 0", in_ready32);
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({in_ready32, in_ready64} !== 2'b11) $display("FAIL ready_after_release: got %b expected 11", {in_ready32, in_ready64});
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_itype;
        out_ready = 1'b1;
        offer(32'hFFF00093, 3'b000, 4'd5);
        total++;
        if ({out_valid32, imm32, ill32, tag32} !== {1'b1, 32'hFFFFFFFF, 1'b0, 4'd5})
            $display("FAIL itype32: got v=%b imm=%h ill=%b tag=%h expected v=1 imm=ffffffff ill=0 tag=5", out_valid32, imm32, ill32, tag32);
        else passed++;
        total++;
        if (imm64 !== 64'hFFFFFFFFFFFFFFFF) $display("FAIL itype64: got %h expected ffffffffffffffff", imm64);
        else passed++;
        @(posedge clk); @(negedge clk);
        total++;
        if (out_valid32 !== 1'b0) $display("FAIL itype_drain: got %b expected 0", out_valid32);
        else passed++;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hFE000EE3; in_immsrc = 3'b010; in_tag = 4'd1;
        @(posedge clk); @(negedge clk);
        in_instr = 32'h008000EF; in_immsrc = 3'b011; in_tag = 4'd2;
        total++;
        if ({out_valid32, imm32, src32, tag32} !== {1'b1, 32'hFFFFFFFC, 3'b010, 4'd1})
            $display("FAIL btype: got v=%b imm=%h src=%h tag=%h expected v=1 imm=fffffffc src=2 tag=1", out_valid32, imm32, src32, tag32);
        else passed++;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        total++;
        if ({out_valid32, imm32, src32, tag32} !== {1'b1, 32'h00000008, 3'b011, 4'd2})
            $display("FAIL jtype: got v=%b imm=%h src=%h tag=%h expected v=1 imm=00000008 src=3 tag=2", out_valid32, imm32, src32, tag32);
        else passed++;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_xlen64;
        out_ready = 1'b1;
        offer(32'h800003B7, 3'b100, 4'd3);
        total++;
        if ({imm64, imm32} !== {64'hFFFFFFFF80000000, 32'h80000000})
            $display("FAIL utype: got %h/%h expected ffffffff80000000/80000000", imm64, imm32);
        else passed++;
        offer(32'h03F00013, 3'b110, 4'd4);
        total++;
        if ({imm64, imm32} !== {64'h000000000000003F, 32'h0000001F})
            $display("FAIL shamt: got %h/%h expected 000000000000003f/0000001f", imm64, imm32);
        else passed++;
        offer(32'h800F8073, 3'b101, 4'd6);
        total++;
        if ({imm64, imm32} !== {64'h000000000000001F, 32'h0000001F})
            $display("FAIL zimm: got %h/%h expected 000000000000001f/0000001f", imm64, imm32);
        else passed++;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reserved;
        out_ready = 1'b1;
        offer($urandom, 3'b111, 4'hA);
        total++;
        if ({imm32, ill32, tag32, src32} !== {32'h0, 1'b1, 4'hA, 3'b111})
            $display("FAIL reserved32: got imm=%h ill=%b tag=%h src=%h expected imm=0 ill=1 tag=a src=7", imm32, ill32, tag32, src32);
        else passed++;
        total++;
        if ({imm64, ill64} !== {64'h0, 1'b1})
            $display("FAIL reserved64: got imm=%h ill=%b expected imm=0 ill=1", imm64, ill64);
        else passed++;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_backpressure;
        int accepted;
        int n_out;
        logic [3:0]  got_tag[3];
        logic [31:0] got_imm[3];
        logic        acc;
        accepted = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid  = 1'b1;
            in_tag    = 4'(accepted + 1);
            in_immsrc = 3'b000;
            in_instr  = {4'(accepted + 1), 8'h00, 20'h00013};
            #1;
            if (in_ready32) accepted++;
            @(posedge clk); @(negedge clk);
        end
        total++;
        if (accepted !== 2 || in_ready32 !== 1'b0 || in_ready64 !== 1'b0)
            $display("FAIL bp_stall: got accepted=%0d ready=%b expected accepted=2 ready=0", accepted, in_ready32);
        else passed++;
        total++;
        if ({out_valid32, tag32, imm32} !== {1'b1, 4'd1, 32'h00000100})
            $display("FAIL bp_hold: got v=%b tag=%h imm=%h expected v=1 tag=1 imm=00000100", out_valid32, tag32, imm32);
        else passed++;
        out_ready = 1'b1;
        n_out = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (out_valid32 && out_ready) begin
                if (n_out < 3) begin
                    got_tag[n_out] = tag32;
                    got_imm[n_out] = imm32;
                end
                n_out++;
            end
            acc = in_valid && in_ready32;
            @(posedge clk); @(negedge clk);
            if (acc) in_valid = 1'b0;
        end
        total++;
        if (n_out !== 3) $display("FAIL bp_count: got %0d expected 3", n_out);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            if (k < n_out) begin
                total++;
                if ({got_tag[k], got_imm[k]} !== {4'(k + 1), 32'((k + 1) * 256)})
                    $display("FAIL bp_order%0d: got tag=%h imm=%h expected tag=%h imm=%h", k, got_tag[k], got_imm[k], k + 1, (k + 1) * 256);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_full;
        logic seen;
        out_ready = 1'b0;
        offer(32'h00100093, 3'b000, 4'd7);
        offer(32'h00200093, 3'b000, 4'd8);
        total++;
        if ({out_valid32, in_ready32} !== 2'b10) $display("FAIL rf_full: got %b expected 10", {out_valid32, in_ready32});
        else passed++;
        #2 reset = 1'b1;
        #1;
        total++;
        if ({out_valid32, in_ready32, out_valid64, in_ready64} !== 4'b0000)
            $display("FAIL rf_async: got %b expected 0000", {out_valid32, in_ready32, out_valid64, in_ready64});
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready32 !== 1'b1) $display("FAIL rf_ready: got %b expected 1", in_ready32);
        else passed++;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid32 || out_valid64) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) $display("FAIL rf_no_ghost: got %b expected 0", seen);
        else passed++;
    endtask

    task automatic test_random;
        exp_t        e;
        logic [63:0] r;
        logic        prev_stall;
        logic [31:0] p_imm32;
        logic [63:0] p_imm64;
        logic [3:0]  p_tag;
        prev_stall = 1'b0;
        p_imm32 = '0; p_imm64 = '0; p_tag = '0;
        for (int c = 0; c < 420; c++) begin
            if (c < 400) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            in_instr  = $urandom;
            in_immsrc = 3'($urandom_range(0, 7));
            in_tag    = 4'($urandom);
            #1;
            total++;
            if (in_ready32 !== (q.size() < 2) || in_ready64 !== in_ready32 || out_valid32 !== (q.size() != 0))
                $display("FAIL rnd_occ c=%0d: got ready=%b valid=%b expected ready=%b valid=%b", c, in_ready32, out_valid32, q.size() < 2, q.size() != 0);
            else passed++;
            if (prev_stall) begin
                total++;
                if ({imm32, imm64, tag32} !== {p_imm32, p_imm64, p_tag})
                    $display("FAIL rnd_stable c=%0d: got %h/%h/%h expected %h/%h/%h", c, imm32, imm64, tag32, p_imm32, p_imm64, p_tag);
                else passed++;
            end
            if (out_valid32 && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    $display("FAIL rnd_extra c=%0d: got output expected none", c);
                end else begin
                    e = q.pop_front();
                    if ({imm32, src32, tag32, ill32, imm64, src64, tag64, ill64} !== {e.i32, e.src, e.tag, e.ill, e.i64, e.src, e.tag, e.ill})
                        $display("FAIL rnd_data c=%0d: got %h %h %h %b / %h expected %h %h %h %b / %h",
                                 c, imm32, src32, tag32, ill32, imm64, e.i32, e.src, e.tag, e.ill, e.i64);
                    else passed++;
                end
            end
            if (in_valid && in_ready32) begin
                e.i64 = ref_imm(in_instr, in_immsrc, 64);
                r     = ref_imm(in_instr, in_immsrc, 32);
                e.i32 = r[31:0];
                e.src = in_immsrc;
                e.tag = in_tag;
                e.ill = (in_immsrc == 3'b111);
                q.push_back(e);
            end
            prev_stall = out_valid32 && !out_ready;
            p_imm32 = imm32; p_imm64 = imm64; p_tag = tag32;
            @(posedge clk); @(negedge clk);
        end
        total++;
        if (q.size() != 0) $display("FAIL rnd_drain: got %0d left expected 0", q.size());
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_itype();
        test_back_to_back();
        test_xlen64();
        test_reserved();
        test_backpressure();
        test_reset_full();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
